// File: rtl/int16_to_float32_seq.sv
// Sequential int16 (two's complement) to IEEE-754 float32 converter.
// The sign and magnitude are latched, then the magnitude is normalised with
// an iterative shifter that moves up to SHIFT_STEP positions per cycle.
// The result is held until downstream accepts it.
// Every int16 value is exact in float32, so no rounding is needed.
module int16_to_float32_seq #(
  parameter int unsigned SHIFT_STEP = 1  // legal values: 1, 2, 4, 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_int,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_float
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sign;
  logic [15:0] r_mag;
  logic [4:0]  r_cnt;
  logic        r_valid;
  logic [31:0] r_float;

  logic [15:0] w_abs;
  logic [4:0]  w_k;
  logic [7:0]  w_exp;
  logic        w_mag_zero;
  logic        w_normalised;

  // Magnitude of the incoming sample. -32768 maps to 16'h8000, which is
  // correct when the result is read as unsigned.
  always_comb begin
    w_abs = i_int[15] ? (~i_int + 16'd1) : i_int;
  end

  // Shift amount for one normalise step: the largest k in 1..SHIFT_STEP
  // whose top k bits are all zero, so the leading one is never passed.
  // This is evaluated only while the top bit is clear, so k is at least 1.
  always_comb begin
    w_k = 5'd1;
    for (int unsigned i = 1; i <= SHIFT_STEP; i++) begin
      if ((r_mag >> (16 - i)) == 16'd0) begin
        w_k = 5'(i);
      end
    end
  end

  // Normalisation status and the biased exponent: 127 + 15 - shift count.
  always_comb begin
    w_mag_zero   = (r_mag == 16'd0);
    w_normalised = r_mag[15];
    w_exp        = 8'd142 - {3'b000, r_cnt};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_next = NORM;
        end
      end
      NORM: begin
        if (w_mag_zero || w_normalised) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode. Ready is asserted only in IDLE; valid and data are registered.
  always_comb begin
    o_ready = (r_state == IDLE);
    o_valid = r_valid;
    o_float = r_float;
  end

  // Datapath: latch sign and magnitude, shift toward the leading one,
  // then pack the result and hold it until it is consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_float <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_sign <= i_int[15];
            r_mag  <= w_abs;
            r_cnt  <= '0;
          end
        end
        NORM: begin
          if (w_mag_zero) begin
            r_float <= '0;
            r_valid <= 1'b1;
          end else if (w_normalised) begin
            r_float <= {r_sign, w_exp, r_mag[14:0], 8'h00};
            r_valid <= 1'b1;
          end else begin
            r_mag <= r_mag << w_k;
            r_cnt <= r_cnt + w_k;
          end
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
